if_id_skid: RTL and testbench
=============================

Name: if_id_skid

Overview:
- Parametrised IF->ID pipeline stage, successor to the plain IF/ID register.
- Adds valid/ready handshake, a 2-entry skid buffer, synchronous flush and bubble insertion.
- Generic PC/instruction widths plus an exception/sideband field.
- Sits between fetch and decode. Lets decode stall without a combinational ready path back into fetch.

Parameters:
- ADDR_W, 32, PC width.
- INST_W, 32, instruction width.
- SB_W, 4, sideband width (exception code, predicted-taken, etc.); must be >=1.
- BUBBLE_INST, 32'h0000_0000, instruction presented downstream when no valid entry; INST_W bits.
- CNT_W, 32, perf counter width (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  synchronous kill of all held entries (branch mispredict/exception).
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept; driven from a register only.
- in_pc  in  ADDR_W  fetch PC.
- in_inst  in  INST_W  fetched instruction.
- in_sb  in  SB_W  fetch sideband.
- out_valid  out  1  decode-side entry valid.
- out_ready  in  1  decode consumes this cycle.
- out_pc  out  ADDR_W  PC of head entry.
- out_inst  out  INST_W  instruction of head entry, or BUBBLE_INST.
- out_sb  out  SB_W  sideband of head entry.

Behaviour:
- Storage: main entry (drives outputs) and skid entry, each with its own valid bit.
- Occupancy states: EMPTY (0), ONE (main valid), FULL (main+skid valid).
- Handshake:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Data transfers only on these; upstream must hold in_* stable while in_valid & ~in_ready.
- in_ready = ~skid_valid (registered). It is high in EMPTY and ONE and low in FULL.
- Latency: accepted instruction appears on out_* the cycle after acceptance when the stage was EMPTY, or ONE with pop.
- Transitions (no flush):
  - EMPTY: accept -> ONE (main <= in).
  - ONE, accept & pop -> ONE (main <= in).
  - ONE, accept & ~pop -> FULL (skid <= in).
  - ONE, ~accept & pop -> EMPTY.
  - ONE, ~accept & ~pop -> hold.
  - FULL, pop -> ONE (main <= skid, skid invalid); accept is impossible.
  - FULL, ~pop -> hold.
- Ordering: strict FIFO; the skid entry is never presented before main.
- Outputs when out_valid=0:
  - out_inst = BUBBLE_INST, out_pc = 0, out_sb = 0.
  - Outputs are registered; no combinational in->out path.
- Flush, highest priority:
  - Next state EMPTY; both valids cleared.
  - An instruction accepted in the flush cycle is dropped.
  - A pop in the flush cycle still counts as consumed by decode.
  - in_ready = 1 the cycle after flush.
- Reset, asynchronous, any cycle including mid-transfer:
  - Both valids 0, in_ready=1, out_valid=0.
  - out_inst=BUBBLE_INST, out_pc=0, out_sb=0.
  - No entry survives reset. First accept is allowed on the first clock edge with rst low.
- Stable outputs: out_* do not change while out_valid & ~out_ready.
- Widths: all fields are copied bit-exactly; no arithmetic on PC.

Optional Feature:
- Macro: IF_ID_SKID_PERF_EN.
- Defined:
  - Adds outputs stall_cnt and bubble_cnt, CNT_W each.
  - stall_cnt increments each cycle out_valid & ~out_ready.
  - bubble_cnt increments each cycle ~out_valid & ~flush.
  - Both saturate at all-ones and clear on rst only; flush does not clear them.
- Undefined: ports and logic absent; handshake behaviour identical.

Test Plan:
- Reset release:
  - Assert rst asynchronously mid-cycle while FULL.
  - Require immediately out_valid=0, in_ready=1, out_inst=0x00000000.
  - After release, accept pc=0x1000 inst=0x00000013; out_valid=1, out_pc=0x1000 next cycle.
- Streaming:
  - in_valid=1 and out_ready=1 continuously with pcs 0x0,0x4,0x8,0xC.
  - Outputs appear one cycle later in order, in_ready stays 1, zero bubbles.
- Stall/skid:
  - out_ready=0 for 3 cycles while sending 0x20,0x24,0x28.
  - 0x20 held on outputs, 0x24 in skid, in_ready=0, 0x28 held upstream.
  - On out_ready=1, sequence 0x20,0x24,0x28 emerges with no loss or duplication.
- Flush while FULL with accept attempted:
  - Next cycle out_valid=0, out_inst=BUBBLE_INST, in_ready=1.
  - Neither held PC nor the flush-cycle PC ever appears.
- Simultaneous accept+pop in ONE: main replaced by new entry; state stays ONE; no skid use.
- IF_ID_SKID_PERF_EN build:
  - 5 stall cycles and 2 idle cycles yield stall_cnt=5, bubble_cnt=2.
  - With CNT_W=3 and 10 stalls, stall_cnt saturates at 7.

Source files
------------

// File: rtl/if_id_skid.sv
// IF->ID pipeline stage: valid/ready handshake, 2-entry skid buffer, flush and bubble insertion.
// Optional performance counters are enabled by defining IF_ID_SKID_PERF_EN.
module if_id_skid #(
  parameter int unsigned         ADDR_W      = 32,
  parameter int unsigned         INST_W      = 32,
  parameter int unsigned         SB_W        = 4,
  parameter logic [INST_W-1:0]   BUBBLE_INST = '0,
  parameter int unsigned         CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [INST_W-1:0] in_inst,
  input  logic [SB_W-1:0]   in_sb,
`ifdef IF_ID_SKID_PERF_EN
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [SB_W-1:0]   out_sb
);

  if (SB_W < 1) begin : g_sb_w_chk
    $error("if_id_skid: SB_W must be >= 1");
  end
  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("if_id_skid: CNT_W must be >= 1");
  end

  // Encoding doubles as the valid bits: bit0 = main valid, bit1 = skid valid.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] main_pc_q, main_pc_d;
  logic [INST_W-1:0] main_inst_q, main_inst_d;
  logic [SB_W-1:0]   main_sb_q, main_sb_d;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
  logic [INST_W-1:0] skid_inst_q, skid_inst_d;
  logic [SB_W-1:0]   skid_sb_q, skid_sb_d;

  logic accept;
  logic pop;

  assign in_ready  = ~state_q[1];
  assign out_valid = state_q[0];
  assign out_pc    = main_pc_q;
  assign out_inst  = main_inst_q;
  assign out_sb    = main_sb_q;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_pc_d   = main_pc_q;
    main_inst_d = main_inst_q;
    main_sb_d   = main_sb_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    skid_sb_d   = skid_sb_q;

    if (flush) begin
      state_d     = EMPTY;
      main_pc_d   = '0;
      main_inst_d = BUBBLE_INST;
      main_sb_d   = '0;
      skid_pc_d   = '0;
      skid_inst_d = '0;
      skid_sb_d   = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d     = ONE;
            main_pc_d   = in_pc;
            main_inst_d = in_inst;
            main_sb_d   = in_sb;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_pc_d   = in_pc;
            main_inst_d = in_inst;
            main_sb_d   = in_sb;
          end else if (accept) begin
            state_d     = FULL;
            skid_pc_d   = in_pc;
            skid_inst_d = in_inst;
            skid_sb_d   = in_sb;
          end else if (pop) begin
            state_d     = EMPTY;
            main_pc_d   = '0;
            main_inst_d = BUBBLE_INST;
            main_sb_d   = '0;
          end
        end
        FULL: begin
          if (pop) begin
            state_d     = ONE;
            main_pc_d   = skid_pc_q;
            main_inst_d = skid_inst_q;
            main_sb_d   = skid_sb_q;
            skid_pc_d   = '0;
            skid_inst_d = '0;
            skid_sb_d   = '0;
          end
        end
        default: begin
          state_d     = EMPTY;
          main_pc_d   = '0;
          main_inst_d = BUBBLE_INST;
          main_sb_d   = '0;
          skid_pc_d   = '0;
          skid_inst_d = '0;
          skid_sb_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_pc_q   <= '0;
      main_inst_q <= BUBBLE_INST;
      main_sb_q   <= '0;
      skid_pc_q   <= '0;
      skid_inst_q <= '0;
      skid_sb_q   <= '0;
    end else begin
      state_q     <= state_d;
      main_pc_q   <= main_pc_d;
      main_inst_q <= main_inst_d;
      main_sb_q   <= main_sb_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      skid_sb_q   <= skid_sb_d;
    end
  end

`ifdef IF_ID_SKID_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating counters; flush deliberately leaves them untouched.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (!out_valid && !flush && (bubble_cnt_q != {CNT_W{1'b1}}))
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_skid.sv
// Directed self-checking bench for if_id_skid; perf-counter checks compile in with IF_ID_SKID_PERF_EN.
module tb_if_id_skid;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic [3:0]  in_sb;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [3:0]  out_sb;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

`ifdef IF_ID_SKID_PERF_EN
  logic [31:0] stall_cnt, bubble_cnt;
  logic [2:0]  stall_cnt3, bubble_cnt3;
  logic        in_ready3, out_valid3;
  logic [31:0] out_pc3, out_inst3;
  logic [3:0]  out_sb3;
`endif

  if_id_skid dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .in_sb     (in_sb),
`ifdef IF_ID_SKID_PERF_EN
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .out_sb    (out_sb)
  );

`ifdef IF_ID_SKID_PERF_EN
  if_id_skid #(.CNT_W(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready3),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .in_sb     (in_sb),
    .stall_cnt (stall_cnt3),
    .bubble_cnt(bubble_cnt3),
    .out_valid (out_valid3),
    .out_ready (out_ready),
    .out_pc    (out_pc3),
    .out_inst  (out_inst3),
    .out_sb    (out_sb3)
  );
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  function automatic logic [3:0] sb_of(input logic [31:0] pc);
    return pc[5:2] ^ 4'h5;
  endfunction

  task automatic drive(input logic [31:0] pc);
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst_of(pc);
    in_sb    = sb_of(pc);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_pc    = 32'hDEAD_BEEF;
    in_inst  = 32'hDEAD_BEEF;
    in_sb    = 4'hF;
  endtask

  task automatic chk_entry(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_pc"},    out_pc,    pc);
    check({tag, "_inst"},  out_inst,  inst_of(pc));
    check({tag, "_sb"},    out_sb,    sb_of(pc));
  endtask

  task automatic chk_bubble(input string tag);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_pc"},    out_pc,    32'h0);
    check({tag, "_inst"},  out_inst,  32'h0);
    check({tag, "_sb"},    out_sb,    4'h0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    idle();
    #2;
    chk_bubble("por");
    check("por_in_ready", in_ready, 1'b1);
    step();
    rst = 1'b0;

    // Fill to FULL, then async reset mid-cycle
    drive(32'h0000_0100); step();
    drive(32'h0000_0104); step();
    check("fill_in_ready", in_ready, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk_bubble("rst_mid");
    check("rst_mid_in_ready", in_ready, 1'b1);
    idle(); step();
    rst = 1'b0;
    drive(32'h0000_1000);
    in_inst = 32'h0000_0013;
    step();
    idle();
    check("rel_valid", out_valid, 1'b1);
    check("rel_pc", out_pc, 32'h0000_1000);
    check("rel_inst", out_inst, 32'h0000_0013);
    out_ready = 1'b1; step();
    chk_bubble("drain0");

    // Streaming
    for (int i = 0; i < 4; i++) begin
      drive(32'(i * 4));
      check("stream_in_ready", in_ready, 1'b1);
      step();
      chk_entry("stream", 32'(i * 4));
    end
    idle(); step();
    chk_bubble("stream_end");

    // Stall / skid
    out_ready = 1'b0;
    drive(32'h20); step();
    chk_entry("stall1", 32'h20);
    check("stall1_in_ready", in_ready, 1'b1);
    drive(32'h24); step();
    chk_entry("stall2", 32'h20);
    check("stall2_in_ready", in_ready, 1'b0);
    drive(32'h28); step();
    chk_entry("stall3", 32'h20);
    check("stall3_in_ready", in_ready, 1'b0);
    out_ready = 1'b1; step();
    chk_entry("unstall1", 32'h24);
    check("unstall1_in_ready", in_ready, 1'b1);
    step();
    chk_entry("unstall2", 32'h28);
    idle(); step();
    chk_bubble("unstall_end");

    // Flush while FULL with accept attempted
    out_ready = 1'b0;
    drive(32'h40); step();
    drive(32'h44); step();
    check("ffull_in_ready", in_ready, 1'b0);
    drive(32'h48); flush = 1'b1; step();
    flush = 1'b0; idle();
    chk_bubble("ffull");
    check("ffull_in_ready_post", in_ready, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("ffull_stay_empty", out_valid, 1'b0);
    end

    // Flush in ONE while an accept actually happens
    out_ready = 1'b0;
    drive(32'h50); step();
    drive(32'h54); flush = 1'b1; step();
    flush = 1'b0; idle();
    chk_bubble("fone");
    step();
    chk_bubble("fone_later");

    // Simultaneous accept + pop in ONE
    out_ready = 1'b1;
    drive(32'h60); step();
    chk_entry("ap1", 32'h60);
    drive(32'h64); step();
    chk_entry("ap2", 32'h64);
    check("ap2_in_ready", in_ready, 1'b1);
    idle(); step();
    chk_bubble("ap_end");

`ifdef IF_ID_SKID_PERF_EN
    rst = 1'b1; out_ready = 1'b0; idle();
    step();
    rst = 1'b0;
    step();
    drive(32'h80); step();
    idle();
    repeat (5) step();
    check("perf_stall", stall_cnt, 32'd5);
    check("perf_bubble", bubble_cnt, 32'd2);
    check("perf3_stall5", stall_cnt3, 3'd5);
    repeat (10) step();
    check("perf_stall15", stall_cnt, 32'd15);
    check("perf3_sat", stall_cnt3, 3'd7);
    check("perf_bubble_hold", bubble_cnt, 32'd2);
    out_ready = 1'b1; step();
    check("perf_pop_valid", out_valid, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
